// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and helpers for the single-clock FIFO
package sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Widest word the parity helper accepts; callers zero-extend into it
    localparam int PARITY_MAX_W = 1024;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    // Even parity bit: makes the total count of ones in {bit, data} even
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port array with a registered read port
module sync_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Array write port; the array itself is never reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read-port next value: load on enable, otherwise hold
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read output register; only this register is reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO, standard/FWFT read, optional parity (SYNC_FIFO_PARITY_EN)
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PTR_W = ptr_w(ADDR_WIDTH);
    localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam logic [PTR_W-1:0] DEPTH_LVL  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);
    localparam logic [PTR_W-1:0] ONE        = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_valid_q, rd_valid_d;
    logic [MEM_W-1:0] head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [MEM_W-1:0] fwd_data_q, fwd_data_d;

    logic                  push;
    logic                  pop;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [MEM_W-1:0]      mem_rd_data;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      head_src;
    logic                  mem_has_data;
    logic [MEM_W-1:0]      out_word;

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {even_parity(PARITY_MAX_W'(wr_data)), wr_data};
`else
    assign wr_word = wr_data;
`endif

    sync_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (MEM_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // Datapath: accept/reject decisions, pointer moves, memory ports and FWFT head register
    always_comb begin
        push         = wr_en && !full_q;
        pop          = rd_en && !empty_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
        mem_has_data = (wr_ptr_q != rd_ptr_q);
        // The read register missed a write that landed on its address last edge
        head_src     = fwd_valid_q ? fwd_data_q : mem_rd_data;
        fwd_valid_d  = 1'b0;
        fwd_data_d   = fwd_data_q;
        if (FWFT == MODE_STD) begin
            mem_wr_en = push;
            mem_rd_en = pop;
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
        end else begin
            // Memory holds only the words behind the head register
            if (pop) begin
                if (mem_has_data) begin
                    head_d   = head_src;
                    rd_ptr_d = rd_ptr_q + ONE;
                    if (push) begin
                        mem_wr_en = 1'b1;
                        wr_ptr_d  = wr_ptr_q + ONE;
                    end
                end else if (push) begin
                    head_d = wr_word;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (push) begin
                if (!head_valid_q) begin
                    head_d       = wr_word;
                    head_valid_d = 1'b1;
                end else begin
                    mem_wr_en = 1'b1;
                    wr_ptr_d  = wr_ptr_q + ONE;
                end
            end
            // Keep the read register pointing at the next head candidate
            mem_rd_en   = 1'b1;
            mem_rd_addr = rd_ptr_d[ADDR_WIDTH-1:0];
            fwd_valid_d = mem_wr_en && (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
            fwd_data_d  = wr_word;
        end
    end

    // Next-state fill level and flags, so every flag leaves a register
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
        if (FWFT == MODE_STD) begin
            full_d     = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                         (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
            empty_d    = (wr_ptr_d == rd_ptr_d);
            rd_valid_d = pop;
        end else begin
            full_d     = (level_d == DEPTH_LVL);
            empty_d    = !head_valid_d;
            rd_valid_d = head_valid_d;
        end
        afull_d     = (level_d >= AFULL_LVL);
        aempty_d    = (level_d <= AEMPTY_LVL);
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
    end

    // State registers; reset clears everything at once without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= (AFULL_THRESH == 0);
            aempty_q     <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            fwd_valid_q  <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            rd_valid_q   <= rd_valid_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign out_word     = (FWFT == MODE_STD) ? mem_rd_data : head_q;
    assign rd_data      = out_word[DATA_WIDTH-1:0];
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign level        = level_q;

`ifdef SYNC_FIFO_PARITY_EN
    assign parity_err = rd_valid_q &&
                        (even_parity(PARITY_MAX_W'(out_word[DATA_WIDTH-1:0])) != out_word[DATA_WIDTH]);
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - queue-model bench for standard and FWFT instances of sync_fifo_ctrl
module tb_sync_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_unf;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_level;
    logic          f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_unf;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_level;
`ifdef SYNC_FIFO_PARITY_EN
    logic          s_perr, f_perr;
`endif

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_f[$];
    logic [DW-1:0] s_last = '0;
    int            s_wr_cnt = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_afull), .overflow(s_ovf),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .empty(s_empty), .almost_empty(s_aempty), .underflow(s_unf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(s_perr),
`endif
        .level(s_level)
    );

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_afull), .overflow(f_ovf),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .empty(f_empty), .almost_empty(f_aempty), .underflow(f_unf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(f_perr),
`endif
        .level(f_level)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string p, input int n,
                             input logic [AW:0] lvl, input logic emp, input logic ful,
                             input logic af, input logic ae, input logic ovf, input logic unf,
                             input logic eovf, input logic eunf);
        chk({p, ".level"},        64'(lvl), 64'(n));
        chk({p, ".empty"},        64'(emp), 64'(n == 0));
        chk({p, ".full"},         64'(ful), 64'(n == DEPTH));
        chk({p, ".almost_full"},  64'(af),  64'(n >= DEPTH - 2));
        chk({p, ".almost_empty"}, 64'(ae),  64'(n <= 2));
        chk({p, ".overflow"},     64'(ovf), 64'(eovf));
        chk({p, ".underflow"},    64'(unf), 64'(eunf));
    endtask

    // One clock of stimulus: model both FIFOs from the pre-edge state, then check after the edge
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        logic s_ovf_e, s_unf_e, s_val_e, f_ovf_e, f_unf_e;
        int   n_s, n_f;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        n_s     = q_s.size();
        n_f     = q_f.size();
        s_ovf_e = w && (n_s == DEPTH);
        s_unf_e = r && (n_s == 0);
        s_val_e = r && (n_s != 0);
        if (s_val_e) s_last = q_s.pop_front();
        if (w && n_s != DEPTH) begin
            q_s.push_back(d);
            s_wr_cnt++;
        end
        f_ovf_e = w && (n_f == DEPTH);
        f_unf_e = r && (n_f == 0);
        if (r && n_f != 0) void'(q_f.pop_front());
        if (w && n_f != DEPTH) q_f.push_back(d);
        @(posedge clk);
        #1;
        chk_flags("std", q_s.size(), s_level, s_empty, s_full, s_afull, s_aempty, s_ovf, s_unf,
                  s_ovf_e, s_unf_e);
        chk("std.rd_valid", 64'(s_rd_valid), 64'(s_val_e));
        chk("std.rd_data",  64'(s_rd_data),  64'(s_last));
        chk_flags("fwft", q_f.size(), f_level, f_empty, f_full, f_afull, f_aempty, f_ovf, f_unf,
                  f_ovf_e, f_unf_e);
        chk("fwft.rd_valid", 64'(f_rd_valid), 64'(q_f.size() != 0));
        if (q_f.size() != 0) chk("fwft.rd_data", 64'(f_rd_data), 64'(q_f[0]));
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string p);
        chk_flags({p, ".std"}, 0, s_level, s_empty, s_full, s_afull, s_aempty, s_ovf, s_unf, 1'b0, 1'b0);
        chk({p, ".std.rd_valid"}, 64'(s_rd_valid), 64'(0));
        chk({p, ".std.rd_data"},  64'(s_rd_data),  64'(0));
        chk_flags({p, ".fwft"}, 0, f_level, f_empty, f_full, f_afull, f_aempty, f_ovf, f_unf, 1'b0, 1'b0);
        chk({p, ".fwft.rd_valid"}, 64'(f_rd_valid), 64'(0));
        chk({p, ".fwft.rd_data"},  64'(f_rd_data),  64'(0));
    endtask

    task automatic model_clear();
        q_s.delete();
        q_f.delete();
        s_last   = '0;
        s_wr_cnt = 0;
    endtask

    task automatic set_level(input int n);
        while (q_s.size() > n) step(1'b0, 1'b1, '0);
        while (q_s.size() < n) step(1'b1, 1'b0, $urandom);
    endtask

    initial begin
        // Power-on reset, checked while asserted and before any clock edge
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x0..0xF, then one write too many
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("fill.level_after_overflow", 64'(s_level), 64'(DEPTH));

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain.order", 64'(s_rd_data), 64'(i));
        end
        step(1'b0, 1'b1, '0);

        // FWFT fall-through of a single word, then pop it
        step(1'b1, 1'b0, 32'h0000_00A5);
        chk("fwft.fallthrough", 64'(f_rd_data), 64'(32'hA5));
        step(1'b0, 1'b1, '0);
        chk("fwft.empty_after_pop", 64'(f_empty), 64'(1));

        // Read and write together on an empty FIFO
        step(1'b1, 1'b1, 32'h1234_5678);
        step(1'b0, 1'b1, '0);

        // Steady state at level 8 across pointer wrap
        set_level(8);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom);
        chk("steady.level", 64'(s_level), 64'(8));

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), $urandom);
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 65), $urandom);

        // Reset between edges at level 5
        set_level(5);
        rst_n = 1'b0;
        #2;
        model_clear();
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0000_003C);
        step(1'b0, 1'b1, '0);
        chk("midreset.readback", 64'(s_rd_data), 64'(32'h3C));

`ifdef SYNC_FIFO_PARITY_EN
        begin
            int a;
            set_level(0);
            a = s_wr_cnt % DEPTH;
            step(1'b1, 1'b0, 32'h0F0F_0001);
            step(1'b1, 1'b0, 32'h0F0F_0002);
            dut_std.u_mem.mem_q[a][DW] = ~dut_std.u_mem.mem_q[a][DW];
            step(1'b0, 1'b1, '0);
            chk("parity.flagged", 64'(s_perr), 64'(1));
            step(1'b0, 1'b1, '0);
            chk("parity.clean", 64'(s_perr), 64'(0));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO for same-domain buffering between pipeline stages. It generalises the dual-clock FIFO to one clock and adds the following:
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- an exact fill-level output
- overflow and underflow error pulses

It is used wherever producer and consumer share clk, so no Gray-code pointer crossing is needed.

Parameters:
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH (fixed, not a separate parameter)
DATA_WIDTH, 32, data word width in bits
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through mode
AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full asserts when level >= this value
AEMPTY_THRESH, 2, almost_empty asserts when level <= this value

Ports:
clk  in  1  single clock; all logic is on its rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  no free entry
almost_full  out  1  level >= AFULL_THRESH
overflow  out  1  one-cycle pulse: wr_en seen while full
rd_en  in  1  read request (standard mode) or pop (FWFT mode)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a newly read word
empty  out  1  no readable word
almost_empty  out  1  level <= AEMPTY_THRESH
underflow  out  1  one-cycle pulse: rd_en seen while empty
level  out  ADDR_WIDTH+1  number of stored words, range 0..DEPTH

Behaviour:
- Reset (async assert, sync release by the integrator): pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0 (unless AFULL_THRESH == 0), overflow 0, underflow 0, rd_valid 0, rd_data 0.
- Reset asserted mid-operation: contents are discarded; outputs return to reset values immediately, without waiting for clk.
- Pointers: ADDR_WIDTH+1 bits. The MSB is the wrap bit.
  - full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (the lower address bits are equal).
  - empty = pointers equal.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
- Write accepted = wr_en && !full.
  - Full blocks writes even if a read is accepted in the same cycle.
  - wr_en while full: the word is dropped, no state changes, and overflow pulses on the next cycle.
- Standard mode (FWFT=0):
  - Read accepted = rd_en && !empty.
  - rd_data is registered: the word appears after the edge that accepts the read, and rd_valid is high for exactly that cycle.
  - rd_data holds its value otherwise.
  - A read and a write in the same cycle on an empty FIFO: the read is rejected (underflow pulses) and the write is accepted.
- FWFT mode (FWFT=1):
  - A prefetch output register holds the head word. empty = !head_valid.
  - When the register is empty, a write bypasses directly into it, so empty drops one edge after the write.
  - rd_en && !empty pops the head; the next word is loaded at the same edge, giving back-to-back pops at full rate.
  - rd_valid = !empty.
  - level counts memory words plus the head register.
- Level and flags:
  - level: +1 on an accepted write, −1 on an accepted read, unchanged when both or neither occur.
  - All flags are registered from next-state values: no combinational path from inputs to flags.
- underflow: pulses one cycle after rd_en while empty.

Optional Feature:
Macro SYNC_FIFO_PARITY_EN.
- Defined:
  - The memory stores DATA_WIDTH+1 bits; the extra bit is the even parity of wr_data.
  - On each read the parity is recomputed, and output parity_err (1 bit, reset 0) is high in the cycle rd_valid presents a mismatching word.
- Undefined: the memory stores DATA_WIDTH bits and the parity_err port is absent.

Decomposition:
- Package sync_fifo_pkg holds the localparam helpers:
  - PTR_W = ADDR_WIDTH+1
  - the parity function
  - the read-mode constants MODE_STD = 0 and MODE_FWFT = 1
- One sub-module, sync_fifo_mem: a simple dual-port array (write port, registered read port, no reset on the array). This keeps the memory inferable as block RAM.

Test Plan:
- Standard mode (ADDR_WIDTH=4): write 16 words 0x0..0xF → full=1, level=16, almost_full=1 from level 14. A 17th write gives overflow pulse=1 and the level stays 16.
- Standard mode: 16 reads → rd_data = 0x0..0xF, each one cycle after rd_en with rd_valid. Afterwards empty=1 and almost_empty=1 at level ≤2. An extra rd_en gives an underflow pulse.
- FWFT mode: a single write of 0xA5 into the empty FIFO → after 1 edge empty=0 and rd_data=0xA5 without rd_en. rd_en pops it and empty=1 on the next edge.
- Simultaneous: at level 8, wr_en and rd_en held for 40 cycles → level stays 8, order is preserved across pointer wrap, and there is no overflow or underflow.
- Reset mid-stream: at level 5, pull rst_n low between edges → empty=1, level=0 and rd_valid=0 immediately. After release, a write/read of 0x3C returns 0x3C.
- With SYNC_FIFO_PARITY_EN defined: force a stored bit flip via a hierarchical deposit → parity_err=1 in the rd_valid cycle of that word only.
